// File: rtl/relu_activation_stage_pkg.sv
// Shared defaults and sizing helpers for the ReLU activation stage.
package relu_activation_stage_pkg;

   // Project-wide widths and layer geometry.
   localparam int unsigned RELU_NODES        = 4;
   localparam int unsigned LAYER_1_BIT_WIDTH = 8;
   localparam int unsigned ACT_BIT_WIDTH     = 8;
   localparam int unsigned LAYER_VECS        = 16;

   // Output buffer depth; pointers are a single bit.
   localparam int unsigned FIFO_DEPTH = 2;

   typedef logic [1:0] fifo_cnt_t;

   // Width of a counter that holds 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Comparison width wide enough for the shifted sum and for 2^act_w-1 with a spare bit.
   function automatic int unsigned sat_cmp_width(input int unsigned sum_w, input int unsigned act_w);
      return (sum_w > act_w) ? sum_w : act_w + 1;
   endfunction

endpackage

// File: rtl/relu_activation_stage_relu_sat.sv
// One lane: ReLU, arithmetic right shift, unsigned saturation to ACT_W bits.
module relu_sat
   import relu_activation_stage_pkg::*;
#(
   parameter int unsigned SUM_W = LAYER_1_BIT_WIDTH,
   parameter int unsigned ACT_W = ACT_BIT_WIDTH,
   parameter int unsigned SHIFT = 0
) (
   input  logic [SUM_W-1:0] i_sum,
   output logic [ACT_W-1:0] o_act,
   output logic             o_sat
);

   localparam int unsigned CmpW = sat_cmp_width(SUM_W, ACT_W);

   logic signed [SUM_W-1:0] w_sum;
   logic        [SUM_W-1:0] w_shifted;
   logic        [CmpW-1:0]  w_v_ext;
   logic        [CmpW-1:0]  w_max;

   assign w_sum     = i_sum;
   assign w_shifted = SUM_W'(w_sum >>> SHIFT);
   // Only used for non-negative sums, so the top bit is zero and zero-extension is exact.
   assign w_v_ext   = CmpW'(w_shifted);
   assign w_max     = {{(CmpW - ACT_W){1'b0}}, {ACT_W{1'b1}}};

   // Negative sums clamp to zero; large positives clamp to all-ones and flag saturation.
   always_comb begin
      o_act = '0;
      o_sat = 1'b0;
      if (!w_sum[SUM_W-1]) begin
         if (w_v_ext > w_max) begin
            o_act = '1;
            o_sat = 1'b1;
         end else begin
            o_act = w_v_ext[ACT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/relu_activation_stage.sv
// ReLU/saturation stage with a 2-entry output FIFO, layer vector counter and sticky saturation flag.
module relu_activation_stage
   import relu_activation_stage_pkg::*;
#(
   parameter int unsigned NODES = RELU_NODES,
   parameter int unsigned SUM_W = LAYER_1_BIT_WIDTH,
   parameter int unsigned ACT_W = ACT_BIT_WIDTH,
   parameter int unsigned SHIFT = 0,
   parameter int unsigned VECS  = LAYER_VECS
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic [NODES*SUM_W-1:0] sum_in,
   input  logic                   sum_valid,
   output logic                   sum_ready,
   output logic [NODES*ACT_W-1:0] act_out,
   output logic                   act_valid,
   input  logic                   act_ready,
   output logic                   layer_done,
   output logic                   sat_seen
);

   localparam int unsigned CntW = cnt_width(VECS);

   logic [NODES*ACT_W-1:0] r_mem [FIFO_DEPTH];
   logic                   r_wr_ptr;
   logic                   r_rd_ptr;
   fifo_cnt_t              r_count;
   fifo_cnt_t              w_count_d;
   logic [CntW-1:0]        r_vec_cnt;
   logic                   r_layer_done;
   logic                   r_sat_seen;

   logic [NODES*ACT_W-1:0] w_act_vec;
   logic [NODES-1:0]       w_lane_sat;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_last_vec;

   for (genvar g = 0; g < NODES; g++) begin : g_lane
      relu_sat #(
         .SUM_W (SUM_W),
         .ACT_W (ACT_W),
         .SHIFT (SHIFT)
      ) u_relu_sat (
         .i_sum (sum_in[g*SUM_W +: SUM_W]),
         .o_act (w_act_vec[g*ACT_W +: ACT_W]),
         .o_sat (w_lane_sat[g])
      );
   end

   // No pass-through when full: ready depends only on stored occupancy.
   assign sum_ready  = (r_count != fifo_cnt_t'(FIFO_DEPTH));
   assign act_valid  = (r_count != '0);
   assign act_out    = r_mem[r_rd_ptr];
   assign layer_done = r_layer_done;
   assign sat_seen   = r_sat_seen;
   assign w_push     = sum_valid & sum_ready;
   assign w_pop      = act_valid & act_ready;
   assign w_last_vec = (r_vec_cnt == CntW'(VECS - 1));

   // Occupancy next-state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      w_count_d = r_count;
      if (w_push && !w_pop) begin
         w_count_d = r_count + fifo_cnt_t'(1);
      end else if (w_pop && !w_push) begin
         w_count_d = r_count - fifo_cnt_t'(1);
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_act_vec;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= w_count_d;
      end
   end

   // Layer counter: wraps on the VECS-th pop and raises a one-cycle done pulse.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_vec_cnt    <= '0;
         r_layer_done <= 1'b0;
      end else begin
         r_layer_done <= w_pop & w_last_vec;
         if (w_pop) begin
            r_vec_cnt <= w_last_vec ? '0 : r_vec_cnt + CntW'(1);
         end
      end
   end

   // Sticky saturation flag, set only by an accepted vector.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sat_seen <= 1'b0;
      end else if (w_push && (|w_lane_sat)) begin
         r_sat_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_relu_activation_stage.sv
// Directed and randomized checks of relu_activation_stage against a queue-based reference model.
module tb_relu_activation_stage;

   localparam int unsigned NODES = 2;
   localparam int unsigned SUM_W = 8;
   localparam int unsigned ACT_W = 4;
   localparam int unsigned SHIFT = 2;
   localparam int unsigned VECS  = 3;

   logic                   clk;
   logic                   clr;
   logic [NODES*SUM_W-1:0] sum_in;
   logic                   sum_valid;
   logic                   sum_ready;
   logic [NODES*ACT_W-1:0] act_out;
   logic                   act_valid;
   logic                   act_ready;
   logic                   layer_done;
   logic                   sat_seen;

   relu_activation_stage #(
      .NODES (NODES),
      .SUM_W (SUM_W),
      .ACT_W (ACT_W),
      .SHIFT (SHIFT),
      .VECS  (VECS)
   ) u_dut (
      .clk        (clk),
      .clr        (clr),
      .sum_in     (sum_in),
      .sum_valid  (sum_valid),
      .sum_ready  (sum_ready),
      .act_out    (act_out),
      .act_valid  (act_valid),
      .act_ready  (act_ready),
      .layer_done (layer_done),
      .sat_seen   (sat_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   logic [NODES*ACT_W-1:0] q[$];
   int                     pop_cnt;
   logic                   exp_sat;
   logic                   exp_ld;

   function automatic int lane_val(input logic [SUM_W-1:0] b);
      int s;
      s = int'($signed(b));
      if (s < 0) return 0;
      return s / (1 << SHIFT);
   endfunction

   function automatic logic [NODES*ACT_W-1:0] ref_vec(input logic [NODES*SUM_W-1:0] v);
      logic [NODES*ACT_W-1:0] r;
      int                     x;
      r = '0;
      for (int i = 0; i < int'(NODES); i++) begin
         x = lane_val(v[i*SUM_W +: SUM_W]);
         if (x > (1 << ACT_W) - 1) x = (1 << ACT_W) - 1;
         r[i*ACT_W +: ACT_W] = ACT_W'(x);
      end
      return r;
   endfunction

   function automatic logic ref_sat(input logic [NODES*SUM_W-1:0] v);
      logic s;
      s = 1'b0;
      for (int i = 0; i < int'(NODES); i++) begin
         if (lane_val(v[i*SUM_W +: SUM_W]) > (1 << ACT_W) - 1) s = 1'b1;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("act_valid", 32'(act_valid), 32'(q.size() > 0));
      chk("sum_ready", 32'(sum_ready), 32'(q.size() < 2));
      if (q.size() > 0) chk("act_out", 32'(act_out), 32'(q[0]));
      chk("sat_seen", 32'(sat_seen), 32'(exp_sat));
      chk("layer_done", 32'(layer_done), 32'(exp_ld));
   endtask

   task automatic model_reset();
      q.delete();
      pop_cnt = 0;
      exp_sat = 1'b0;
      exp_ld  = 1'b0;
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic cycle(input logic [NODES*SUM_W-1:0] v, input logic sv, input logic ar);
      logic do_push;
      logic do_pop;
      sum_in    = v;
      sum_valid = sv;
      act_ready = ar;
      do_push   = sv && (q.size() < 2);
      do_pop    = ar && (q.size() > 0);
      @(posedge clk);
      exp_ld = 1'b0;
      if (do_pop) begin
         void'(q.pop_front());
         if (pop_cnt == int'(VECS) - 1) begin
            pop_cnt = 0;
            exp_ld  = 1'b1;
         end else begin
            pop_cnt++;
         end
      end
      if (do_push) begin
         q.push_back(ref_vec(v));
         if (ref_sat(v)) exp_sat = 1'b1;
      end
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted between edges, checked before any clock edge.
   task automatic async_reset();
      #2;
      clr = 1'b0;
      #1;
      model_reset();
      chk("rst_act_valid", 32'(act_valid), 32'd0);
      chk("rst_sum_ready", 32'(sum_ready), 32'd1);
      chk("rst_act_out", 32'(act_out), 32'd0);
      chk("rst_sat_seen", 32'(sat_seen), 32'd0);
      chk("rst_layer_done", 32'(layer_done), 32'd0);
      @(posedge clk);
      #1;
      clr = 1'b1;
   endtask

   initial begin
      clr       = 1'b0;
      sum_in    = '0;
      sum_valid = 1'b0;
      act_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("init_act_valid", 32'(act_valid), 32'd0);
      chk("init_sum_ready", 32'(sum_ready), 32'd1);
      chk("init_act_out", 32'(act_out), 32'd0);
      clr = 1'b1;

      // Transform: negative lane clamps to 0, 12>>>2 = 3.
      cycle(16'hF00C, 1'b1, 1'b1);
      chk("xform_value", 32'(act_out), 32'h03);
      cycle(16'h0000, 1'b0, 1'b1);

      // Saturation on both lanes, flag stays set.
      cycle(16'h7155, 1'b1, 1'b1);
      chk("sat_value", 32'(act_out), 32'hFF);
      cycle(16'h0000, 1'b0, 1'b1);
      cycle(16'h0000, 1'b0, 1'b0);

      // Backpressure: three back-to-back pushes with the consumer stalled.
      cycle(16'h0408, 1'b1, 1'b0);
      cycle(16'h0C10, 1'b1, 1'b0);
      cycle(16'h1418, 1'b1, 1'b0);
      cycle(16'h1418, 1'b1, 1'b0);
      cycle(16'h1418, 1'b1, 1'b1);
      cycle(16'h1418, 1'b1, 1'b1);
      cycle(16'h0000, 1'b0, 1'b1);
      cycle(16'h0000, 1'b0, 1'b1);
      cycle(16'h0000, 1'b0, 1'b1);

      // Simultaneous push and pop at occupancy one.
      cycle(16'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(16'($urandom), 1'b1, 1'b1);
      cycle(16'h0000, 1'b0, 1'b1);

      // Reset with two entries buffered.
      cycle(16'($urandom), 1'b1, 1'b0);
      cycle(16'($urandom), 1'b1, 1'b0);
      async_reset();

      // Seven pops: pulses after #3 and #6, then reset and two more pops.
      for (int i = 0; i < 7; i++) begin
         cycle(16'($urandom), 1'b1, 1'b0);
         cycle(16'h0000, 1'b0, 1'b1);
      end
      async_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(16'($urandom), 1'b1, 1'b0);
         cycle(16'h0000, 1'b0, 1'b1);
      end

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         cycle(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
